// File: rtl/lsu_rf_if.sv
// Request/response bus of the lsu_rf block: load/store request handshake,
// register read ports, external write port and completion status.
interface lsu_rf_if #(
   parameter int unsigned DATA_W = 64,
   parameter int unsigned REG_AW = 5
);
   logic              req_valid;
   logic              req_ready;
   logic              req_op;
   logic [REG_AW-1:0] ra;
   logic [REG_AW-1:0] rb;
   logic [REG_AW-1:0] rw;
   logic [DATA_W-1:0] imm;
   logic              we;
   logic [REG_AW-1:0] wa;
   logic [DATA_W-1:0] wdata;
   logic [DATA_W-1:0] douta;
   logic [DATA_W-1:0] doutb;
   logic              done;
   logic              err;
   logic              wr_drop;

   modport master (
      output req_valid, req_op, ra, rb, rw, imm, we, wa, wdata,
      input  req_ready, douta, doutb, done, err, wr_drop
   );

   modport slave (
      input  req_valid, req_op, ra, rb, rw, imm, we, wa, wdata,
      output req_ready, douta, doutb, done, err, wr_drop
   );
endinterface

// File: rtl/lsu_rf.sv
// Register file with an integrated load/store engine and private data memory.
// A request forms addr = imm + reg[rb]; a store writes reg[ra] to mem[addr],
// a load writes mem[addr] to reg[rw]. Out-of-range addresses complete with err.
// Optional feature macro: LSU_RF_ZERO_REG_EN (register 0 hardwired to zero).
module lsu_rf #(
   parameter int unsigned DATA_W  = 64,
   parameter int unsigned REG_AW  = 5,
   parameter int unsigned MEM_AW  = 5,
   parameter int unsigned MEM_LAT = 1
) (
   input logic     clk,
   input logic     rst_n,
   lsu_rf_if.slave bus
);
   localparam int unsigned NREG = 2 ** REG_AW;
   localparam int unsigned NMEM = 2 ** MEM_AW;

   typedef enum logic [1:0] {StIdle, StCalc, StWait, StDone} state_e;

   state_e            r_state;
   state_e            w_state_next;
   logic              r_op;
   logic [REG_AW-1:0] r_rw;
   logic [DATA_W-1:0] r_imm;
   logic [DATA_W-1:0] r_base;
   logic [DATA_W-1:0] r_sdata;
   logic [MEM_AW-1:0] r_addr;
   logic [3:0]        r_cnt;
   logic              r_err;
   logic              r_wr_drop;
   logic [DATA_W-1:0] r_reg [NREG];
   logic [DATA_W-1:0] w_mem [NMEM];

   logic [DATA_W-1:0] w_sum;
   logic              w_oor;
   logic              w_accept;
   logic              w_wb;
   logic              w_ld_wb;
   logic              w_st_wb;
   logic              w_ld_ok;
   logic              w_ext_ok;
   logic              w_ld_we;
   logic              w_ext_we;
   logic              w_drop;

   assign w_sum    = r_imm + r_base;
   assign w_oor    = |w_sum[DATA_W-1:MEM_AW];
   assign w_accept = bus.req_valid & (r_state == StIdle);
   // Access edge: last WAIT cycle
   assign w_wb     = (r_state == StWait) & (r_cnt == 4'd0);
   assign w_ld_wb  = w_wb & r_op;
   assign w_st_wb  = w_wb & ~r_op;

`ifdef LSU_RF_ZERO_REG_EN
   // Writes to register 0 vanish silently; it keeps its reset value of zero
   assign w_ld_ok  = (r_rw != '0);
   assign w_ext_ok = (bus.wa != '0);
`else
   assign w_ld_ok  = 1'b1;
   assign w_ext_ok = 1'b1;
`endif

   // The load write-back owns the register write port; a coinciding external
   // write is dropped even when the load itself is discarded.
   assign w_ld_we  = w_ld_wb & w_ld_ok;
   assign w_ext_we = bus.we & ~w_ld_wb & w_ext_ok;
   assign w_drop   = bus.we & w_ld_wb & w_ext_ok;

   assign bus.douta = r_reg[bus.ra];
   assign bus.doutb = r_reg[bus.rb];

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= StIdle;
      else        r_state <= w_state_next;
   end

   // FSM next-state logic
   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         StIdle:  if (w_accept) w_state_next = StCalc;
         StCalc:  w_state_next = w_oor ? StDone : StWait;
         StWait:  if (r_cnt == 4'd0) w_state_next = StDone;
         StDone:  w_state_next = StIdle;
         default: w_state_next = StIdle;
      endcase
   end

   // FSM outputs
   always_comb begin
      bus.req_ready = (r_state == StIdle);
      bus.done      = (r_state == StDone);
      bus.err       = (r_state == StDone) & r_err;
      bus.wr_drop   = r_wr_drop;
   end

   // Request capture, address/error calculation and latency counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_op      <= 1'b0;
         r_rw      <= '0;
         r_imm     <= '0;
         r_base    <= '0;
         r_sdata   <= '0;
         r_addr    <= '0;
         r_cnt     <= 4'd0;
         r_err     <= 1'b0;
         r_wr_drop <= 1'b0;
      end else begin
         r_wr_drop <= w_drop;
         if (w_accept) begin
            r_op    <= bus.req_op;
            r_rw    <= bus.rw;
            r_imm   <= bus.imm;
            r_base  <= bus.doutb;
            r_sdata <= bus.douta;
         end
         if (r_state == StCalc) begin
            r_addr <= w_sum[MEM_AW-1:0];
            r_err  <= w_oor;
            r_cnt  <= 4'(MEM_LAT - 1);
         end else if (r_state == StWait && r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
         end
         if (r_state == StDone) r_err <= 1'b0;
      end
   end

   // Register file: reset to reg[i] = i, load write-back has priority
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) r_reg[i] <= DATA_W'(i);
      end else if (w_ld_we) begin
         r_reg[r_rw] <= w_mem[r_addr];
      end else if (w_ext_we) begin
         r_reg[bus.wa] <= bus.wdata;
      end
   end

   // Data memory: not reset, powers up as mem[i] = i
   for (genvar g = 0; g < NMEM; g++) begin : g_mem
      logic [DATA_W-1:0] r_word = DATA_W'(g);

      // Store write-back into this word
      always_ff @(posedge clk) begin
         if (w_st_wb && r_addr == MEM_AW'(g)) r_word <= r_sdata;
      end

      assign w_mem[g] = r_word;
   end
endmodule

// File: tb/tb_lsu_rf.sv
// Scoreboard bench for lsu_rf: stimulus pushes expected completions and
// dropped-write pulses into queues, a negedge monitor compares every cycle.
module tb_lsu_rf;
   localparam int unsigned DATA_W  = 64;
   localparam int unsigned REG_AW  = 5;
   localparam int unsigned MEM_AW  = 5;
   localparam int unsigned MEM_LAT = 3;
   localparam int unsigned NREG    = 32;
   localparam int unsigned NMEM    = 32;
`ifdef LSU_RF_ZERO_REG_EN
   localparam bit ZERO = 1'b1;
`else
   localparam bit ZERO = 1'b0;
`endif

   typedef struct {
      int cyc;
      bit err;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_bad = 0;

   logic [63:0] m_reg [NREG];
   logic [63:0] m_mem [NMEM];
   exp_t        exp_q [$];
   int          drop_q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   lsu_rf_if #(.DATA_W(DATA_W), .REG_AW(REG_AW)) bus ();

   lsu_rf #(
      .DATA_W (DATA_W),
      .REG_AW (REG_AW),
      .MEM_AW (MEM_AW),
      .MEM_LAT(MEM_LAT)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
      end
   endtask

   // Monitor: status every cycle, read ports whenever the model says idle
   always @(negedge clk) begin
      bit exp_rdy;
      bit exp_done;
      bit exp_drop;
      exp_rdy  = (exp_q.size() == 0);
      exp_done = !exp_rdy && exp_q[0].cyc == cyc;
      exp_drop = (drop_q.size() > 0) && drop_q[0] == cyc;
      chk("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
      chk("done", 64'(bus.done), 64'(exp_done));
      chk("err", 64'(bus.err), 64'(exp_done ? exp_q[0].err : 1'b0));
      chk("wr_drop", 64'(bus.wr_drop), 64'(exp_drop));
      if (!exp_rdy && exp_q[0].cyc <= cyc) void'(exp_q.pop_front());
      if (drop_q.size() > 0 && drop_q[0] <= cyc) void'(drop_q.pop_front());
      if (exp_rdy) begin
         chk("douta", bus.douta, m_reg[bus.ra]);
         chk("doutb", bus.doutb, m_reg[bus.rb]);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (exp_q.size() > 0 || drop_q.size() > 0) begin
         tick();
         n++;
         if (n > 100) begin
            $display("FAIL idle_timeout cyc=%0d got=busy want=idle", cyc);
            $fatal(1);
         end
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      exp_q.delete();
      drop_q.delete();
      for (int i = 0; i < NREG; i++) m_reg[i] = 64'(i);
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   // Issue one request; the model is updated at acceptance (checked after done)
   task automatic issue(input bit op, input int ra_i, input int rb_i, input int rw_i,
                        input logic [63:0] imm_i, input bit apply, output int acc);
      logic [63:0] addr;
      int          n = 0;
      bus.req_valid = 1'b1;
      bus.req_op    = op;
      bus.ra        = REG_AW'(ra_i);
      bus.rb        = REG_AW'(rb_i);
      bus.rw        = REG_AW'(rw_i);
      bus.imm       = imm_i;
      while (!bus.req_ready) begin
         tick();
         n++;
         if (n > 100) begin
            $display("FAIL ready_timeout cyc=%0d got=0 want=1", cyc);
            $fatal(1);
         end
      end
      addr = imm_i + m_reg[rb_i];
      tick();
      acc = cyc;
      bus.req_valid = 1'b0;
      if (addr >= 64'(NMEM)) begin
         exp_q.push_back('{acc + 1, 1'b1});
      end else begin
         exp_q.push_back('{acc + 1 + MEM_LAT, 1'b0});
         if (apply) begin
            if (op) begin
               if (!(ZERO && rw_i == 0)) m_reg[rw_i] = m_mem[addr[4:0]];
            end else begin
               m_mem[addr[4:0]] = m_reg[ra_i];
            end
         end
      end
   endtask

   task automatic ext_write(input int wa_i, input logic [63:0] wd);
      bus.we    = 1'b1;
      bus.wa    = REG_AW'(wa_i);
      bus.wdata = wd;
      tick();
      bus.we = 1'b0;
      if (!(ZERO && wa_i == 0)) m_reg[wa_i] = wd;
   endtask

   // In-range load with an external write landing on the write-back edge
   task automatic collide(input int rb_i, input int rw_i, input logic [63:0] imm_i,
                          input int wa_i, input logic [63:0] wd);
      int acc;
      issue(1'b1, 0, rb_i, rw_i, imm_i, 1'b1, acc);
      repeat (MEM_LAT) tick();
      bus.we    = 1'b1;
      bus.wa    = REG_AW'(wa_i);
      bus.wdata = wd;
      tick();
      bus.we = 1'b0;
      if (!(ZERO && wa_i == 0)) drop_q.push_back(acc + 1 + MEM_LAT);
   endtask

   task automatic sweep();
      for (int i = 0; i < NREG; i++) begin
         bus.ra = REG_AW'(i);
         bus.rb = REG_AW'(NREG - 1 - i);
         tick();
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
      $fatal(1);
   end

   initial begin
      int          acc;
      int          rb_i;
      logic [63:0] imm_i;
      bus.req_valid = 1'b0;
      bus.req_op    = 1'b0;
      bus.ra        = '0;
      bus.rb        = '0;
      bus.rw        = '0;
      bus.imm       = '0;
      bus.we        = 1'b0;
      bus.wa        = '0;
      bus.wdata     = '0;
      for (int i = 0; i < NMEM; i++) m_mem[i] = 64'(i);
      do_reset();
      sweep();

      // Directed cases
      issue(1'b0, 4, 6, 0, 64'd2, 1'b1, acc);           // mem[8] = 4
      wait_idle();
      issue(1'b1, 0, 0, 31, 64'd8 - m_reg[0], 1'b1, acc); // reg[31] = mem[8]
      wait_idle();
      bus.rb = 5'd31;
      tick();
      issue(1'b1, 0, 13, 2, 64'd3, 1'b1, acc);          // reg[2] = mem[16]
      wait_idle();
      bus.ra = 5'd2;
      tick();
      issue(1'b1, 0, 5, 1, 64'd30, 1'b1, acc);          // addr 35: error
      wait_idle();
      collide(21, 3, 64'd10, 3, 64'd99);                // reg[3] = mem[31]
      wait_idle();
      issue(1'b1, 0, 0, 0, 64'd7 - m_reg[0], 1'b1, acc); // load into reg 0
      wait_idle();
      collide(0, 0, 64'd5 - m_reg[0], 7, 64'd1234);     // load to reg 0 blocks we
      wait_idle();
      ext_write(0, 64'hdead_beef);
      sweep();

      // Randomised traffic
      for (int it = 0; it < 150; it++) begin
         int r;
         int sel;
         rb_i = int'($urandom_range(0, NREG - 1));
         r    = int'($urandom_range(0, 9));
         if (r < 5)      imm_i = 64'($urandom_range(0, 40));
         else if (r < 8) imm_i = 64'($urandom_range(0, NMEM - 1)) - m_reg[rb_i];
         else            imm_i = {$urandom, $urandom};
         sel = int'($urandom_range(0, 9));
         if (sel < 2) begin
            wait_idle();
            ext_write(int'($urandom_range(0, NREG - 1)),
                      ($urandom_range(0, 3) == 0) ? {$urandom, $urandom}
                                                   : 64'($urandom_range(0, 40)));
         end else if (sel < 4 && (imm_i + m_reg[rb_i]) < 64'(NMEM)) begin
            wait_idle();
            collide(rb_i, int'($urandom_range(0, NREG - 1)), imm_i,
                    int'($urandom_range(0, NREG - 1)), {$urandom, $urandom});
         end else begin
            // Back-to-back issue keeps req_valid waiting on req_ready
            if (sel == 9) wait_idle();
            issue(1'($urandom), int'($urandom_range(0, NREG - 1)), rb_i,
                  int'($urandom_range(0, NREG - 1)), imm_i, 1'b1, acc);
            bus.ra = REG_AW'($urandom_range(0, NREG - 1));
            bus.rb = REG_AW'($urandom_range(0, NREG - 1));
         end
      end
      wait_idle();
      sweep();

      // Reset during WAIT: the pending store must not happen
      ext_write(9, 64'h0abc_dcba);
      issue(1'b0, 9, 0, 0, 64'd12 - m_reg[0], 1'b0, acc);
      tick();
      do_reset();
      sweep();
      issue(1'b1, 0, 0, 1, 64'd12 - m_reg[0], 1'b1, acc);
      wait_idle();
      sweep();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
